// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: boots to RESET_PC, fetches, then waits for the
// core to retire. Define FETCH_CTRL_EXC_EN to add the exc/epc exception redirect.
//
// state | meaning
// BOOT  | first cycle after reset release, no request yet
// FETCH | imem_req held with imem_addr=pc until imem_ack
// EXEC  | instruction in flight, waiting for advance (or exc)
module fetch_ctrl #(
    parameter logic [31:2] RESET_PC = 30'h00000C00,
    parameter logic [31:2] EXC_VEC  = 30'h00001060
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:2] npc,
    input  logic        advance,
    input  logic        stall,
    input  logic        imem_ack,
`ifdef FETCH_CTRL_EXC_EN
    input  logic        exc,
`endif
    output logic [31:2] pc,
    output logic        imem_req,
    output logic [31:2] imem_addr,
    output logic        ir_valid,
    output logic [31:0] icount
`ifdef FETCH_CTRL_EXC_EN
    ,
    output logic [31:2] epc
`endif
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } state_t;

    state_t state;

    // pc only moves in EXEC, so the fetch address is stable for the whole FETCH wait
    assign imem_addr = pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= BOOT;
            pc       <= RESET_PC;
            imem_req <= 1'b0;
            ir_valid <= 1'b0;
            icount   <= 32'd0;
`ifdef FETCH_CTRL_EXC_EN
            epc      <= '0;
`endif
        end else begin
            ir_valid <= 1'b0;
            case (state)
                BOOT: begin
                    state    <= FETCH;
                    imem_req <= 1'b1;
                end
                FETCH: begin
                    if (imem_ack) begin
                        state    <= EXEC;
                        imem_req <= 1'b0;
                        ir_valid <= 1'b1;
                    end
                end
                EXEC: begin
`ifdef FETCH_CTRL_EXC_EN
                    // exception wins over a simultaneous advance, which is dropped
                    if (exc && !stall) begin
                        epc      <= pc;
                        pc       <= EXC_VEC;
                        state    <= FETCH;
                        imem_req <= 1'b1;
                    end else
`endif
                    if (advance && !stall) begin
                        pc       <= npc;
                        icount   <= icount + 32'd1;
                        state    <= FETCH;
                        imem_req <= 1'b1;
                    end
                end
                default: begin
                    state    <= BOOT;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: reset release, fetch/ack flow, stall, reset
// mid-fetch, counter/address wrap and (with FETCH_CTRL_EXC_EN) exceptions.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:2] npc;
    logic        advance;
    logic        stall;
    logic        imem_ack;
    logic [31:2] pc;
    logic        imem_req;
    logic [31:2] imem_addr;
    logic        ir_valid;
    logic [31:0] icount;
`ifdef FETCH_CTRL_EXC_EN
    logic        exc;
    logic [31:2] epc;
`endif

    int n_total = 0;
    int n_pass  = 0;

    fetch_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .npc       (npc),
        .advance   (advance),
        .stall     (stall),
        .imem_ack  (imem_ack),
`ifdef FETCH_CTRL_EXC_EN
        .exc       (exc),
        .epc       (epc),
`endif
        .pc        (pc),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .ir_valid  (ir_valid),
        .icount    (icount)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // inputs change and outputs are sampled 1ns after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b0;
        npc      = '0;
        advance  = 1'b0;
        stall    = 1'b0;
        imem_ack = 1'b0;
`ifdef FETCH_CTRL_EXC_EN
        exc      = 1'b0;
`endif
        tick();
        tick();
        check("rst_req",    {31'd0, imem_req}, 32'd0);
        check("rst_pc",     {2'b0, pc}, 32'h00000C00);
        check("rst_icount", icount, 32'd0);
        check("rst_irv",    {31'd0, ir_valid}, 32'd0);

        // reset release: BOOT for one cycle, then FETCH at RESET_PC
        rst = 1'b1;
        tick();
        check("boot_req",  {31'd0, imem_req}, 32'd1);
        check("boot_addr", {2'b0, imem_addr}, 32'h00000C00);

        // three wait cycles with the request held
        for (int i = 0; i < 3; i++) tick();
        check("wait_req",  {31'd0, imem_req}, 32'd1);
        check("wait_addr", {2'b0, imem_addr}, 32'h00000C00);
        check("wait_irv",  {31'd0, ir_valid}, 32'd0);

        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        check("ack_irv", {31'd0, ir_valid}, 32'd1);
        check("ack_req", {31'd0, imem_req}, 32'd0);
        tick();
        check("irv_pulse", {31'd0, ir_valid}, 32'd0);
        check("exec_idle_pc", {2'b0, pc}, 32'h00000C00);

        advance = 1'b1;
        npc     = 30'h00000C01;
        tick();
        advance = 1'b0;
        check("adv_addr",   {2'b0, imem_addr}, 32'h00000C01);
        check("adv_icount", icount, 32'd1);
        check("adv_req",    {31'd0, imem_req}, 32'd1);

        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;

        // stalled advance holds everything
        advance = 1'b1;
        stall   = 1'b1;
        npc     = 30'h00000C05;
        for (int i = 0; i < 4; i++) tick();
        check("stall_pc",     {2'b0, pc}, 32'h00000C01);
        check("stall_icount", icount, 32'd1);
        check("stall_req",    {31'd0, imem_req}, 32'd0);
        stall = 1'b0;
        tick();
        advance = 1'b0;
        check("unstall_pc",     {2'b0, pc}, 32'h00000C05);
        check("unstall_icount", icount, 32'd2);

        // stall is ignored in FETCH
        stall    = 1'b1;
        imem_ack = 1'b1;
        tick();
        stall    = 1'b0;
        imem_ack = 1'b0;
        check("fetch_stall_irv", {31'd0, ir_valid}, 32'd1);

`ifdef FETCH_CTRL_EXC_EN
        exc     = 1'b1;
        advance = 1'b1;
        npc     = 30'h00000C06;
        tick();
        exc     = 1'b0;
        advance = 1'b0;
        check("exc_epc",    {2'b0, epc}, 32'h00000C05);
        check("exc_addr",   {2'b0, imem_addr}, 32'h00001060);
        check("exc_icount", icount, 32'd2);
        check("exc_req",    {31'd0, imem_req}, 32'd1);
        // exc ignored in FETCH
        exc = 1'b1;
        tick();
        exc = 1'b0;
        check("exc_fetch_epc",  {2'b0, epc}, 32'h00000C05);
        check("exc_fetch_addr", {2'b0, imem_addr}, 32'h00001060);
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
`endif

        // reset in the middle of a fetch wait
        advance = 1'b1;
        npc     = 30'h00000C10;
        tick();
        advance = 1'b0;
        check("pre_rst_icount", icount, 32'd3);
        tick();
        check("pre_rst_req", {31'd0, imem_req}, 32'd1);
        rst = 1'b0;
        #1;
        check("mid_rst_req",    {31'd0, imem_req}, 32'd0);
        check("mid_rst_pc",     {2'b0, pc}, 32'h00000C00);
        check("mid_rst_icount", icount, 32'd0);
        imem_ack = 1'b1;
        tick();
        rst      = 1'b1;
        imem_ack = 1'b0;
        tick();
        check("rerel_req",  {31'd0, imem_req}, 32'd1);
        check("rerel_addr", {2'b0, imem_addr}, 32'h00000C00);
        check("rerel_irv",  {31'd0, ir_valid}, 32'd0);
        tick();
        check("rerel_hold", {31'd0, imem_req}, 32'd1);

        // icount and npc wrap
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        force dut.icount = 32'hFFFFFFFF;
        #1;
        release dut.icount;
        #1;
        check("preload", icount, 32'hFFFFFFFF);
        advance = 1'b1;
        npc     = 30'h3FFFFFFF;
        tick();
        advance = 1'b0;
        check("wrap_icount", icount, 32'd0);
        check("wrap_addr",   {2'b0, imem_addr}, 32'h3FFFFFFF);
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        advance = 1'b1;
        npc     = 30'h00000000;
        tick();
        advance = 1'b0;
        check("npc_zero_pc", {2'b0, pc}, 32'd0);
        check("npc_zero_icount", icount, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
